// File: rtl/ms_timeout_sched.sv
// ms_timeout_sched
//   Shared millisecond timeout scheduler for the sideband domain. One prescaler
//   divides sb_clk down to a ms tick. That tick is shared by N_REQ independent
//   timeout channels, and each channel counts down whole milliseconds. The
//   prescaler only runs while at least one channel is busy.
//
// States
//   state   | meaning
//   IDLE    | no channel busy, prescaler held at 0, no ms_tick
//   COUNT   | at least one channel busy, prescaler wraps 0..DIV-1
//
// Ports
//   sb_clk   sideband clock, all logic on posedge
//   rst      synchronous active-low reset
//   start    per-channel arm/reload request, level-sampled
//   cancel   per-channel abort, highest priority
//   dur_ms   packed per-channel durations in ms, CNT_W bits each
//   busy     channel is counting
//   expired  one-cycle timeout pulse per channel
//   ms_tick  one-cycle pulse per elapsed ms, decoded from state
//   active   OR of busy
module ms_timeout_sched #(
    parameter int N_REQ = 4,
    parameter int DIV   = 3,
    parameter int DIV_W = 10,
    parameter int CNT_W = 8
) (
    input  logic                     sb_clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         start,
    input  logic [N_REQ-1:0]         cancel,
    input  logic [N_REQ*CNT_W-1:0]   dur_ms,
    output logic [N_REQ-1:0]         busy,
    output logic [N_REQ-1:0]         expired,
    output logic                     ms_tick,
    output logic                     active
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   pre_q, pre_d;
    logic [CNT_W-1:0]   rem_q [N_REQ];
    logic [CNT_W-1:0]   rem_d [N_REQ];
    logic [N_REQ-1:0]   busy_q, busy_d;
    logic [N_REQ-1:0]   expired_q, expired_d;

    assign ms_tick = (state_q == ST_COUNT) && (pre_q == PRE_LAST);
    assign busy    = busy_q;
    assign expired = expired_q;
    assign active  = |busy_q;

    always_comb begin
        busy_d    = busy_q;
        expired_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rem_d[i] = rem_q[i];
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (cancel[i]) begin
                busy_d[i] = 1'b0;
                rem_d[i]  = '0;
            end else if (start[i]) begin
                if (dur_ms[i*CNT_W +: CNT_W] == '0) begin
                    // Zero-length timeout expires immediately. A start held high
                    // with D=0 must not produce back-to-back pulses.
                    busy_d[i]    = 1'b0;
                    rem_d[i]     = '0;
                    expired_d[i] = ~expired_q[i];
                end else begin
                    // Reload also covers the final-tick cycle, which suppresses
                    // the pending expiry.
                    busy_d[i] = 1'b1;
                    rem_d[i]  = dur_ms[i*CNT_W +: CNT_W];
                end
            end else if (busy_q[i] && ms_tick) begin
                if (rem_q[i] == CNT_W'(1)) begin
                    busy_d[i]    = 1'b0;
                    rem_d[i]     = '0;
                    expired_d[i] = 1'b1;
                end else begin
                    rem_d[i] = rem_q[i] - CNT_W'(1);
                end
            end
        end

        state_d = (|busy_d) ? ST_COUNT : ST_IDLE;

        // The prescaler starts from 0 on the first COUNT cycle and is cleared
        // on the edge that drops back to IDLE.
        if ((state_d == ST_IDLE) || (state_q == ST_IDLE)) begin
            pre_d = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + DIV_W'(1);
        end
    end

    always_ff @(posedge sb_clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            busy_q    <= '0;
            expired_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                rem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
            for (int i = 0; i < N_REQ; i++) begin
                rem_q[i] <= rem_d[i];
            end
        end
    end

endmodule
